// File: rtl/coh_dcache.sv
// Direct-mapped, 2-word-block, write-back MSI L1 data cache with snoop service and halt flush.
// Optional LL/SC link tracking is compiled in when DCACHE_LLSC_EN is defined.
module coh_dcache #(
  parameter int NSETS = 8
) (
  input  logic        CLK,
  input  logic        nRST,
  input  logic        dmemREN,
  input  logic        dmemWEN,
  input  logic        datomic,
  input  logic [31:0] dmemaddr,
  input  logic [31:0] dmemstore,
  output logic [31:0] dmemload,
  output logic        dhit,
  input  logic        halt,
  output logic        flushed,
  output logic        dREN,
  output logic        dWEN,
  output logic [31:0] daddr,
  output logic [31:0] dstore,
  input  logic [31:0] dload,
  input  logic        dwait,
  output logic        cctrans,
  output logic        ccwrite,
  input  logic        ccwait,
  input  logic        ccinv,
  input  logic [31:0] ccsnoopaddr
);
  localparam int IW = $clog2(NSETS);
  localparam int TW = 29 - IW;
  localparam logic [1:0] MI = 2'd0, MS = 2'd1, MM = 2'd2;

  typedef enum logic [3:0] {
    IDLE, WB0, WB1, ALLOC0, ALLOC1, SNP, SNPWB0, SNPWB1, FLUSH, DONE
  } state_t;

  state_t state, nstate;

  logic [TW-1:0] tags [NSETS];
  logic [31:0]   dw0  [NSETS];
  logic [31:0]   dw1  [NSETS];
  logic [1:0]    mst  [NSETS];
  logic [IW-1:0] fidx;
  logic          flushing, flushed_r;

  logic [IW-1:0] ri, si, widx;
  logic [TW-1:0] rtag, stag;
  logic          rd, wr, rmatch, rdhit, wrhit, smatch, snp_dirty, beat;
  logic          core_go, wr_do, flush_last, sc_fail;
  logic [31:0]   rword;
  state_t        ret;

  assign ri         = dmemaddr[2+IW:3];
  assign rtag       = dmemaddr[31:3+IW];
  assign si         = ccsnoopaddr[2+IW:3];
  assign stag       = ccsnoopaddr[31:3+IW];
  // Write-back beats serve either the miss victim or the flush scan index.
  assign widx       = flushing ? fidx : ri;
  assign wr         = dmemWEN;
  assign rd         = dmemREN & ~dmemWEN;
  assign rmatch     = (mst[ri] != MI) && (tags[ri] == rtag);
  assign rdhit      = rd && rmatch;
  assign wrhit      = wr && rmatch && (mst[ri] == MM);
  assign rword      = dmemaddr[2] ? dw1[ri] : dw0[ri];
  assign smatch     = (mst[si] != MI) && (tags[si] == stag);
  assign snp_dirty  = smatch && (mst[si] == MM);
  assign beat       = (state == WB1) || (state == ALLOC1) || (state == SNPWB1);
  assign core_go    = (state == IDLE) && !ccwait && !halt;
  assign wr_do      = core_go && wrhit && !sc_fail;
  assign flush_last = (fidx == IW'(NSETS - 1));
  assign ret        = flushed_r ? DONE : (flushing ? FLUSH : IDLE);
  assign flushed    = flushed_r;

`ifdef DCACHE_LLSC_EN
  logic        link_v, sc, sc_ok;
  logic [29:0] link_a;
  assign sc      = wr & datomic;
  assign sc_ok   = link_v && (link_a == dmemaddr[31:2]);
  assign sc_fail = sc & ~sc_ok;
  logic unused_bits;
  assign unused_bits = ^{dmemaddr[1:0], ccsnoopaddr[2:0]};
`else
  assign sc_fail = 1'b0;
  logic unused_bits;
  assign unused_bits = ^{dmemaddr[1:0], ccsnoopaddr[2:0], datomic};
`endif

  always_ff @(posedge CLK, negedge nRST) begin
    if (!nRST) state <= IDLE;
    else       state <= nstate;
  end

  always_comb begin
    nstate = state;
    case (state)
      IDLE: begin
        if (ccwait)                           nstate = SNP;
        else if (halt)                        nstate = FLUSH;
        else if (rdhit || wrhit || sc_fail)   nstate = IDLE;
        else if (rd || wr)                    nstate = (mst[ri] == MM) ? WB0 : ALLOC0;
      end
      WB0:    if (!dwait) nstate = WB1;
      WB1:    if (!dwait) nstate = flushing ? FLUSH : ALLOC0;
      ALLOC0: if (!dwait) nstate = ALLOC1;
      ALLOC1: if (!dwait) nstate = IDLE;
      SNP: begin
        if (snp_dirty)    nstate = SNPWB0;
        else if (!ccwait) nstate = ret;
      end
      SNPWB0: if (!dwait) nstate = SNPWB1;
      SNPWB1: if (!dwait) nstate = ret;
      FLUSH: begin
        if (ccwait)              nstate = SNP;
        else if (mst[fidx] == MM) nstate = WB0;
        else if (flush_last)     nstate = DONE;
      end
      DONE:    if (ccwait) nstate = SNP;
      default: nstate = IDLE;
    endcase
  end

  always_comb begin
    dhit     = 1'b0;
    dmemload = '0;
    dREN     = 1'b0;
    dWEN     = 1'b0;
    daddr    = '0;
    dstore   = '0;
    cctrans  = 1'b0;
    ccwrite  = 1'b0;
    case (state)
      IDLE: begin
        if (!ccwait && !halt) begin
          dhit = rdhit | wrhit | sc_fail;
          if (rdhit || wrhit) dmemload = rword;
`ifdef DCACHE_LLSC_EN
          if (sc && (wrhit || sc_fail)) dmemload = {31'd0, sc_ok};
`endif
        end
      end
      WB0, WB1: begin
        dWEN   = 1'b1;
        daddr  = {tags[widx], widx, beat, 2'b00};
        dstore = beat ? dw1[widx] : dw0[widx];
      end
      ALLOC0, ALLOC1: begin
        dREN    = 1'b1;
        cctrans = 1'b1;
        ccwrite = dmemWEN;
        daddr   = {dmemaddr[31:3], beat, 2'b00};
      end
      SNP: begin
        cctrans = snp_dirty;
        ccwrite = snp_dirty;
      end
      SNPWB0, SNPWB1: begin
        cctrans = 1'b1;
        ccwrite = 1'b1;
        dWEN    = 1'b1;
        daddr   = {ccsnoopaddr[31:3], beat, 2'b00};
        dstore  = beat ? dw1[si] : dw0[si];
      end
      default: ;
    endcase
  end

  always_ff @(posedge CLK, negedge nRST) begin
    if (!nRST) begin
      for (int i = 0; i < NSETS; i++) mst[i] <= MI;
      fidx      <= '0;
      flushing  <= 1'b0;
      flushed_r <= 1'b0;
`ifdef DCACHE_LLSC_EN
      link_v    <= 1'b0;
      link_a    <= '0;
`endif
    end else begin
      case (state)
        IDLE:   if (!ccwait && halt) flushing <= 1'b1;
        WB1:    if (!dwait) mst[widx] <= MI;
        ALLOC1: if (!dwait) mst[ri] <= dmemWEN ? MM : MS;
        SNP:    if (smatch && (mst[si] == MS) && ccinv) mst[si] <= MI;
        SNPWB1: if (!dwait) mst[si] <= ccinv ? MI : MS;
        FLUSH: begin
          if (!ccwait && (mst[fidx] != MM)) begin
            if (flush_last) flushed_r <= 1'b1;
            else            fidx <= fidx + 1'b1;
          end
        end
        default: ;
      endcase
`ifdef DCACHE_LLSC_EN
      if (core_go && rdhit && datomic) begin
        link_v <= 1'b1;
        link_a <= dmemaddr[31:2];
      end
      // Any completed store to the linked word, and every SC, breaks the link.
      if (core_go && (wrhit || sc_fail) && (sc || (link_a == dmemaddr[31:2])))
        link_v <= 1'b0;
      if ((state == SNP) && ccinv && (link_a[29:1] == ccsnoopaddr[31:3]))
        link_v <= 1'b0;
`endif
    end
  end

  always_ff @(posedge CLK) begin
    if (wr_do) begin
      if (dmemaddr[2]) dw1[ri] <= dmemstore;
      else             dw0[ri] <= dmemstore;
    end
    if ((state == ALLOC0) && !dwait) dw0[ri] <= dload;
    if ((state == ALLOC1) && !dwait) begin
      dw1[ri]  <= dload;
      tags[ri] <= rtag;
    end
  end

endmodule

// File: tb/tb_coh_dcache.sv
// Directed and randomized bench for coh_dcache against a flat word-memory reference model.
module tb_coh_dcache;
  logic        CLK = 1'b0;
  logic        nRST;
  logic        dmemREN, dmemWEN, datomic, halt, dwait, ccwait, ccinv;
  logic [31:0] dmemaddr, dmemstore, dload, ccsnoopaddr;
  logic [31:0] dmemload, daddr, dstore;
  logic        dhit, flushed, dREN, dWEN, cctrans, ccwrite;

  coh_dcache #(.NSETS(8)) dut (
    .CLK(CLK), .nRST(nRST), .dmemREN(dmemREN), .dmemWEN(dmemWEN), .datomic(datomic),
    .dmemaddr(dmemaddr), .dmemstore(dmemstore), .dmemload(dmemload), .dhit(dhit),
    .halt(halt), .flushed(flushed), .dREN(dREN), .dWEN(dWEN), .daddr(daddr),
    .dstore(dstore), .dload(dload), .dwait(dwait), .cctrans(cctrans), .ccwrite(ccwrite),
    .ccwait(ccwait), .ccinv(ccinv), .ccsnoopaddr(ccsnoopaddr)
  );

  always #5 CLK = ~CLK;

  int nvec = 0;
  int nfail = 0;
  bit [31:0] mem    [bit [31:0]];
  bit [31:0] golden [bit [31:0]];
  int        nrd = 0, nwr = 0;
  logic [31:0] rd_a [64];
  logic [31:0] wr_a [64];
  logic [31:0] wr_d [64];
  bit          rd_cct [64], rd_ccw [64], wr_cct [64], wr_ccw [64];
  bit          stall = 1'b0;

  function automatic logic [31:0] init_val(input logic [31:0] a);
    return (a * 32'h9E3779B1) ^ 32'h5A5A0F0F;
  endfunction

  function automatic logic [31:0] memval(input logic [31:0] a);
    return mem.exists(a) ? mem[a] : init_val(a);
  endfunction

  function automatic logic [31:0] gold(input logic [31:0] a);
    return golden.exists(a) ? golden[a] : init_val(a);
  endfunction

  function automatic logic [31:0] raddr();
    logic [31:0] t, i, w;
    t = $urandom_range(0, 3);
    i = $urandom_range(0, 7);
    w = $urandom_range(0, 1);
    return 32'h1000 | (t << 6) | (i << 3) | (w << 2);
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Memory side: inputs settle 2 units after the falling edge, beats are logged just before the rising edge.
  initial begin
    dwait = 1'b1;
    dload = '0;
    forever begin
      @(negedge CLK);
      #2;
      dwait = stall ? 1'b1 : ($urandom_range(0, 3) == 0);
      dload = memval(daddr);
      #2;
      if (!dwait && dWEN) begin
        mem[daddr] = dstore;
        wr_a[nwr % 64] = daddr; wr_d[nwr % 64] = dstore;
        wr_cct[nwr % 64] = cctrans; wr_ccw[nwr % 64] = ccwrite;
        nwr++;
      end else if (!dwait && dREN) begin
        rd_a[nrd % 64] = daddr; rd_cct[nrd % 64] = cctrans; rd_ccw[nrd % 64] = ccwrite;
        nrd++;
      end
    end
  end

  task automatic op(input bit r, input bit w, input bit at, input logic [31:0] a,
                    input logic [31:0] d, output logic [31:0] q, output int lat);
    @(negedge CLK);
    dmemREN = r; dmemWEN = w; datomic = at; dmemaddr = a; dmemstore = d;
    lat = 0;
    #1;
    while (!dhit && lat < 300) begin
      @(negedge CLK); #1; lat++;
    end
    chk("op_done", {31'd0, dhit}, 32'd1);
    q = dmemload;
    @(negedge CLK);
    dmemREN = 1'b0; dmemWEN = 1'b0; datomic = 1'b0;
  endtask

  task automatic snoop(input logic [31:0] a, input bit inv, input int k);
    int n;
    @(negedge CLK);
    ccwait = 1'b1; ccsnoopaddr = a; ccinv = inv;
    repeat (k) @(negedge CLK);
    ccwait = 1'b0;
    n = 0;
    #1;
    while (cctrans && n < 100) begin
      @(negedge CLK); #1; n++;
    end
    chk("snoop_end", {31'd0, cctrans}, 32'd0);
    @(negedge CLK);
    ccinv = 1'b0;
  endtask

  initial begin
    logic [31:0] q, old;
    int lat, r0, w0, n;
    bit w, r;
    logic [31:0] a, d;
    nRST = 1'b0; dmemREN = 0; dmemWEN = 0; datomic = 0; halt = 0;
    ccwait = 0; ccinv = 0; ccsnoopaddr = '0; dmemaddr = '0; dmemstore = '0;

    repeat (2) @(negedge CLK);
    #1;
    chk("rst_dhit", {31'd0, dhit}, 32'd0);
    chk("rst_dREN", {31'd0, dREN}, 32'd0);
    chk("rst_dWEN", {31'd0, dWEN}, 32'd0);
    chk("rst_cctrans", {31'd0, cctrans}, 32'd0);
    chk("rst_ccwrite", {31'd0, ccwrite}, 32'd0);
    chk("rst_flushed", {31'd0, flushed}, 32'd0);
    chk("rst_daddr", daddr, 32'd0);
    @(negedge CLK); nRST = 1'b1;

    // Reset in the middle of a stalled fill
    stall = 1'b1;
    @(negedge CLK); dmemREN = 1'b1; dmemaddr = 32'h300;
    repeat (3) @(negedge CLK);
    #1;
    chk("midrst_busy_dREN", {31'd0, dREN}, 32'd1);
    chk("midrst_busy_cctrans", {31'd0, cctrans}, 32'd1);
    nRST = 1'b0;
    #1;
    chk("midrst_dREN", {31'd0, dREN}, 32'd0);
    chk("midrst_cctrans", {31'd0, cctrans}, 32'd0);
    chk("midrst_daddr", daddr, 32'd0);
    @(negedge CLK); dmemREN = 1'b0; stall = 1'b0; nRST = 1'b1;

    // Cold load, then repeat hit
    r0 = nrd; w0 = nwr;
    op(1, 0, 0, 32'h100, 0, q, lat);
    chk("cold_load", q, gold(32'h100));
    chk("cold_rd_beats", nrd - r0, 2);
    chk("cold_rd_a0", rd_a[r0 % 64], 32'h100);
    chk("cold_rd_a1", rd_a[(r0 + 1) % 64], 32'h104);
    chk("cold_cctrans", {31'd0, rd_cct[r0 % 64]}, 32'd1);
    chk("cold_ccwrite", {30'd0, rd_ccw[r0 % 64], rd_ccw[(r0 + 1) % 64]}, 32'd0);
    chk("cold_wr_beats", nwr - w0, 0);
    r0 = nrd;
    op(1, 0, 0, 32'h100, 0, q, lat);
    chk("hit_load", q, gold(32'h100));
    chk("hit_lat", lat, 0);
    chk("hit_rd_beats", nrd - r0, 0);

    // Store to S line upgrades with BusRdX, then a store hit in M
    r0 = nrd;
    op(0, 1, 0, 32'h100, 32'hDEADBEEF, q, lat);
    golden[32'h100] = 32'hDEADBEEF;
    chk("upg_rd_beats", nrd - r0, 2);
    chk("upg_ccwrite", {30'd0, rd_ccw[r0 % 64], rd_ccw[(r0 + 1) % 64]}, 32'd3);
    r0 = nrd; w0 = nwr;
    op(0, 1, 0, 32'h104, 32'h12345678, q, lat);
    golden[32'h104] = 32'h12345678;
    chk("st_hit_lat", lat, 0);
    chk("st_hit_bus", (nrd - r0) + (nwr - w0), 0);

    // Conflict miss evicts dirty 0x100 block
    r0 = nrd; w0 = nwr;
    op(1, 0, 0, 32'h140, 0, q, lat);
    chk("evict_load", q, gold(32'h140));
    chk("evict_wr_beats", nwr - w0, 2);
    chk("evict_wr_a0", wr_a[w0 % 64], 32'h100);
    chk("evict_wr_a1", wr_a[(w0 + 1) % 64], 32'h104);
    chk("evict_wr_d0", wr_d[w0 % 64], 32'hDEADBEEF);
    chk("evict_wr_d1", wr_d[(w0 + 1) % 64], 32'h12345678);
    chk("evict_cctrans", {31'd0, wr_cct[w0 % 64]}, 32'd0);
    chk("evict_rd_a0", rd_a[r0 % 64], 32'h140);

    // Snoop of an M line supplies data and downgrades to S; invalidating snoop on S
    op(0, 1, 0, 32'h100, 32'hCAFEF00D, q, lat);
    golden[32'h100] = 32'hCAFEF00D;
    w0 = nwr;
    snoop(32'h104, 1'b0, 2);
    chk("snp_wr_beats", nwr - w0, 2);
    chk("snp_wr_a0", wr_a[w0 % 64], 32'h100);
    chk("snp_wr_a1", wr_a[(w0 + 1) % 64], 32'h104);
    chk("snp_wr_d0", wr_d[w0 % 64], 32'hCAFEF00D);
    chk("snp_ccwrite", {30'd0, wr_ccw[w0 % 64], wr_ccw[(w0 + 1) % 64]}, 32'd3);
    r0 = nrd;
    op(1, 0, 0, 32'h100, 0, q, lat);
    chk("snp_s_load", q, 32'hCAFEF00D);
    chk("snp_s_lat", lat, 0);
    w0 = nwr;
    snoop(32'h100, 1'b1, 2);
    chk("inv_wr_beats", nwr - w0, 0);
    r0 = nrd;
    op(1, 0, 0, 32'h100, 0, q, lat);
    chk("inv_load", q, 32'hCAFEF00D);
    chk("inv_miss", {31'd0, lat > 0}, 32'd1);
    chk("inv_rd_beats", nrd - r0, 2);

`ifdef DCACHE_LLSC_EN
    op(1, 0, 1, 32'h200, 0, q, lat);
    chk("ll_load", q, gold(32'h200));
    op(0, 1, 1, 32'h200, 32'h0BADF00D, q, lat);
    chk("sc_ok", q, 32'd1);
    golden[32'h200] = 32'h0BADF00D;
    op(1, 0, 1, 32'h200, 0, q, lat);
    chk("ll_load2", q, 32'h0BADF00D);
    snoop(32'h200, 1'b1, 2);
    op(0, 1, 1, 32'h200, 32'h11111111, q, lat);
    chk("sc_fail", q, 32'd0);
    op(1, 0, 0, 32'h200, 0, q, lat);
    chk("sc_fail_mem", q, 32'h0BADF00D);
`else
    op(1, 0, 0, 32'h200, 0, q, lat);
    old = gold(32'h200);
    op(0, 1, 1, 32'h200, 32'h0BADF00D, q, lat);
    chk("sc_plain_old", q, old);
    golden[32'h200] = 32'h0BADF00D;
    op(1, 0, 1, 32'h200, 0, q, lat);
    chk("sc_plain_load", q, 32'h0BADF00D);
`endif

    // Randomized loads, stores and snoops
    for (int i = 0; i < 400; i++) begin
      a = raddr();
      if ($urandom_range(0, 9) == 0) begin
        snoop(a, 1'($urandom_range(0, 1)), $urandom_range(1, 3));
      end else begin
        w = 1'($urandom_range(0, 1));
        r = w ? 1'($urandom_range(0, 1)) : 1'b1;
        d = $urandom;
        op(r, w, 0, a, d, q, lat);
        if (w) golden[a] = d;
        else   chk("rand_load", q, gold(a));
      end
    end

    // Leave every set clean, then dirty sets 2 and 5 only
    for (int i = 0; i < 8; i++) begin
      a = 32'h8000 + 32'(i * 8);
      op(1, 0, 0, a, 0, q, lat);
      chk("clean_load", q, gold(a));
    end
    op(0, 1, 0, 32'h010, 32'hA1A1A1A1, q, lat);
    golden[32'h010] = 32'hA1A1A1A1;
    op(0, 1, 0, 32'h028, 32'hB2B2B2B2, q, lat);
    golden[32'h028] = 32'hB2B2B2B2;

    w0 = nwr;
    @(negedge CLK); halt = 1'b1;
    n = 0;
    #1;
    while (!flushed && n < 500) begin
      @(negedge CLK); #1; n++;
    end
    chk("flushed", {31'd0, flushed}, 32'd1);
    chk("flush_wr_beats", nwr - w0, 4);
    chk("flush_a0", wr_a[w0 % 64], 32'h010);
    chk("flush_a1", wr_a[(w0 + 1) % 64], 32'h014);
    chk("flush_a2", wr_a[(w0 + 2) % 64], 32'h028);
    chk("flush_a3", wr_a[(w0 + 3) % 64], 32'h02C);
    chk("flush_d0", wr_d[w0 % 64], 32'hA1A1A1A1);
    repeat (5) @(negedge CLK);
    #1;
    chk("flushed_sticky", {31'd0, flushed}, 32'd1);
    foreach (golden[k]) chk("mem_final", memval(k), golden[k]);

    nRST = 1'b0;
    #1;
    chk("flushed_rst", {31'd0, flushed}, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
    $finish;
  end
endmodule

// File: doc/coh_dcache.md
Name: coh_dcache

Overview:
- Per-core L1 data cache. Sits between the core's memory stage and that core's lane of the coherence controller.
- Direct-mapped, 2-word blocks, write-back, write-allocate, MSI coherence.
- Issues BusRd/BusRdX transactions, answers snoops from the other core, and flushes dirty lines on halt.

Parameters:
- NSETS, 8, number of sets (power of 2); index width IW = log2(NSETS).

Ports:
- CLK  in  1  clock
- nRST  in  1  reset, asynchronous, active-low
- dmemREN  in  1  core load request
- dmemWEN  in  1  core store request
- datomic  in  1  LL (with REN) / SC (with WEN) qualifier
- dmemaddr  in  32  core word address
- dmemstore  in  32  store data
- dmemload  out  32  load data (SC: 1 success / 0 fail)
- dhit  out  1  request completes this cycle
- halt  in  1  core halted
- flushed  out  1  flush complete, sticky
- dREN  out  1  bus read
- dWEN  out  1  bus write
- daddr  out  32  bus word address
- dstore  out  32  bus write data
- dload  in  32  bus read data
- dwait  in  1  low = current bus word done this cycle
- cctrans  out  1  coherence transaction active
- ccwrite  out  1  requester: write intent (BusRdX); snoopee: supplying dirty data
- ccwait  in  1  snoop pending, freeze core side
- ccinv  in  1  invalidate snooped line
- ccsnoopaddr  in  32  snooped address

Behaviour:
- Address split: tag = [31:3+IW], index = [2+IW:3], word = [2], byte = [1:0] (ignored).
- Per line: tag, two data words, MSI state (I/S/M). On reset all lines are I.
- Reset values of all outputs are 0. The FSM resets to IDLE and flushed to 0.
- FSM states: IDLE, WB0, WB1, ALLOC0, ALLOC1, SNP, SNPWB0, SNPWB1, FLUSH, DONE.
- IDLE handling, in priority order:
  - ccwait=1: go to SNP; dhit=0.
  - halt=1: go to FLUSH.
  - Read hit (S or M): dhit=1 and dmemload=word, in the same cycle, combinationally.
  - Write hit in M: dhit=1; update the word the same cycle.
  - Write hit in S: treated as a miss, so the line is re-fetched with BusRdX.
  - Miss with victim in M: go to WB0.
  - Miss otherwise: go to ALLOC0.
- WB0/WB1: dWEN=1, daddr = victim block word 0 then word 1, dstore = victim data. Each beat advances when dwait=0. After WB1 the victim becomes I and the FSM goes to ALLOC0. cctrans=0 throughout.
- ALLOC0/ALLOC1:
  - cctrans=1; ccwrite = dmemWEN; dREN=1; daddr = request block word 0 then word 1.
  - dload is captured on dwait=0.
  - After ALLOC1 the line state is M if the request is a write, otherwise S. The FSM returns to IDLE and the request hits on the next cycle.
- SNP (one cycle): compare ccsnoopaddr to the indexed line.
  - Match in M: ccwrite=1, cctrans=1, go to SNPWB0.
  - Match in S with ccinv=1: go to I.
  - Otherwise: no change; return to IDLE when ccwait falls.
- SNPWB0/SNPWB1: cctrans=1, ccwrite=1, dWEN=1, daddr = snoop block word 0/1, dstore = line data. Each beat advances on dwait=0. At the end the line becomes I if ccinv else S, then go to IDLE.
- A snoop arriving during ALLOC or WB does not preempt. The controller defers it until cctrans drops.
- FLUSH:
  - Scan indices 0..NSETS-1; write back each M line (2 beats, dWEN, cctrans=0) and set it to I.
  - Non-M lines take 1 cycle each.
  - After the last index go to DONE; flushed=1 held until reset.
  - ccwait during FLUSH is serviced between lines via SNP.
- Reset mid-transaction: all buses drop to 0 immediately and all lines become I.
- Simultaneous dmemREN and dmemWEN: the write takes precedence.

Optional Feature:
- DCACHE_LLSC_EN defined:
  - Load with datomic=1 sets link valid and records the word address in a link register.
  - Store with datomic=1 succeeds only if link valid and the addresses match. On success it performs the store and returns dmemload=1; on failure it does not write and returns dmemload=0. Either way it clears the link.
  - The link is also cleared by any core store to the linked address and by any snoop with ccinv=1 matching the linked block.
- Undefined: datomic is ignored, SC behaves as a plain store, and dmemload is the old word value.

Test Plan:
- Load 0x100 cold: ALLOC0/ALLOC1 issue cctrans=1, ccwrite=0, daddr 0x100 then 0x104. After fill, the line is S and dhit=1 with dmemload=RAM[0x100]. Repeat load → dhit the same cycle with no bus activity.
- Store 0xDEADBEEF to 0x100 with the line in S: BusRdX refill (ccwrite=1), line becomes M. Next store to 0x104 hits with no bus activity.
- Line 0x100 in M, then load 0x140 (same index, NSETS=8): WB0/WB1 write 0x100/0x104 dirty data, then allocate 0x140.
- Line 0x100 in M; ccwait=1, ccsnoopaddr=0x104, ccinv=0: ccwrite=1 and dWEN beats carry both words; line ends S. Repeat with ccinv=1 on an S line → I, next load misses.
- halt=1 with M lines at indices 2 and 5: exactly 4 dWEN beats; flushed=1 after index 7 and stays 1.
- With DCACHE_LLSC_EN: LL 0x200 then SC 0x200 → dmemload=1. LL 0x200, snoop ccinv 0x200, SC → dmemload=0 and memory unchanged.
